// File: rtl/demodulator.sv
// rtl/demodulator.sv - coherent 4-phase demodulator with serial bit re-output
// Correlates 32-sample symbols against sine/cosine references and decides the bit pair.
module demodulator #(
  parameter int          SAMPLES_PER_SYM = 32,
  parameter logic [20:0] ERR_THRESH      = 21'd64000
) (
  input  logic               clk_fast,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         wav_in,
  output logic [1:0]         sym_out,
  output logic               sym_valid,
  output logic               sym_err,
  output logic signed [20:0] corr_i,
  output logic signed [20:0] corr_q,
  output logic               bit_out,
  output logic               bit_strobe
);

  localparam logic [4:0] LAST_K = 5'(SAMPLES_PER_SYM - 1);

  typedef enum logic {
    SER_IDLE,
    SER_SHIFT
  } ser_state_e;

  // First quadrant of round(127*sin(2*pi*j/32)), j = 0..8.
  function automatic logic signed [7:0] quarter_wave(input logic [3:0] j);
    logic signed [7:0] v;
    case (j)
      4'd0:    v = 8'sd0;
      4'd1:    v = 8'sd25;
      4'd2:    v = 8'sd49;
      4'd3:    v = 8'sd71;
      4'd4:    v = 8'sd90;
      4'd5:    v = 8'sd106;
      4'd6:    v = 8'sd117;
      4'd7:    v = 8'sd125;
      4'd8:    v = 8'sd127;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

  function automatic logic signed [7:0] sine_lut(input logic [4:0] idx);
    logic [4:0]        mirror;
    logic [3:0]        j;
    logic signed [7:0] m;
    mirror = 5'd16 - {1'b0, idx[3:0]};
    j      = idx[3] ? mirror[3:0] : idx[3:0];
    m      = quarter_wave(j);
    return idx[4] ? -m : m;
  endfunction

  function automatic logic [20:0] abs21(input logic signed [20:0] x);
    return x[20] ? 21'(-x) : 21'(x);
  endfunction

  logic [4:0]         k_q, k_d;
  logic signed [20:0] acc_i_q, acc_i_d;
  logic signed [20:0] acc_q_q, acc_q_d;
  logic [1:0]         sym_q, sym_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic signed [20:0] corr_i_q, corr_i_d;
  logic signed [20:0] corr_q_q, corr_q_d;

  logic signed [7:0]  s_w;
  logic signed [7:0]  sin_w;
  logic signed [7:0]  cos_w;
  logic signed [15:0] prod_i_w;
  logic signed [15:0] prod_q_w;
  logic signed [20:0] sum_i_w;
  logic signed [20:0] sum_q_w;
  logic [20:0]        mag_i_w;
  logic [20:0]        mag_q_w;

  assign s_w      = signed'({~wav_in[7], wav_in[6:0]});
  assign sin_w    = sine_lut(k_q);
  assign cos_w    = sine_lut(k_q + 5'd8);
  assign prod_i_w = s_w * sin_w;
  assign prod_q_w = s_w * cos_w;
  // Sample 0 restarts the sums so a completed symbol never needs a separate clear cycle.
  assign sum_i_w  = (k_q == 5'd0) ? {{5{prod_i_w[15]}}, prod_i_w}
                                  : acc_i_q + {{5{prod_i_w[15]}}, prod_i_w};
  assign sum_q_w  = (k_q == 5'd0) ? {{5{prod_q_w[15]}}, prod_q_w}
                                  : acc_q_q + {{5{prod_q_w[15]}}, prod_q_w};
  assign mag_i_w  = abs21(sum_i_w);
  assign mag_q_w  = abs21(sum_q_w);

  always_comb begin
    k_d      = k_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    sym_d    = sym_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    corr_i_d = corr_i_q;
    corr_q_d = corr_q_q;
    if (in_valid) begin
      k_d     = k_q + 5'd1;
      acc_i_d = sum_i_w;
      acc_q_d = sum_q_w;
      if (k_q == LAST_K) begin
        k_d      = 5'd0;
        valid_d  = 1'b1;
        corr_i_d = sum_i_w;
        corr_q_d = sum_q_w;
        if (mag_i_w >= mag_q_w) begin
          sym_d = sum_i_w[20] ? 2'b11 : 2'b00;
          err_d = mag_i_w < ERR_THRESH;
        end else begin
          sym_d = sum_q_w[20] ? 2'b10 : 2'b01;
          err_d = mag_q_w < ERR_THRESH;
        end
      end
    end else if (k_q != 5'd0) begin
      k_d     = 5'd0;
      acc_i_d = '0;
      acc_q_d = '0;
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      sym_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      corr_i_q <= '0;
      corr_q_q <= '0;
    end else begin
      k_q      <= k_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      sym_q    <= sym_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      corr_i_q <= corr_i_d;
      corr_q_q <= corr_q_d;
    end
  end

  ser_state_e ser_state_q, ser_state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       bit_q, bit_d;
  logic       low_q, low_d;
  logic       strobe_q, strobe_d;

  // A new decision always wins, which gives the seamless reload on cycle 31.
  always_comb begin
    ser_state_d = ser_state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    low_d       = low_q;
    strobe_d    = 1'b0;
    if (valid_q) begin
      ser_state_d = SER_SHIFT;
      cnt_d       = 5'd0;
      bit_d       = sym_q[1];
      low_d       = sym_q[0];
      strobe_d    = 1'b1;
    end else if (ser_state_q == SER_SHIFT) begin
      if (cnt_q == 5'd31) begin
        ser_state_d = SER_IDLE;
      end else begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          bit_d    = low_q;
          strobe_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      ser_state_q <= SER_IDLE;
      cnt_q       <= '0;
      bit_q       <= 1'b0;
      low_q       <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      ser_state_q <= ser_state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      low_q       <= low_d;
      strobe_q    <= strobe_d;
    end
  end

  assign sym_out    = sym_q;
  assign sym_valid  = valid_q;
  assign sym_err    = err_q;
  assign corr_i     = corr_i_q;
  assign corr_q     = corr_q_q;
  assign bit_out    = bit_q;
  assign bit_strobe = strobe_q;

endmodule

// File: tb/tb_demodulator.sv
// tb/tb_demodulator.sv - directed self-checking bench for demodulator
module tb_demodulator;

  logic               clk_fast;
  logic               rst;
  logic               in_valid;
  logic [7:0]         wav_in;
  logic [1:0]         sym_out;
  logic               sym_valid;
  logic               sym_err;
  logic signed [20:0] corr_i;
  logic signed [20:0] corr_q;
  logic               bit_out;
  logic               bit_strobe;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int sinv [32] = '{0, 25, 49, 71, 90, 106, 117, 125, 127, 125, 117, 106, 90, 71, 49, 25,
                    0, -25, -49, -71, -90, -106, -117, -125, -127, -125, -117, -106, -90, -71, -49, -25};

  int         sv_cyc[$];
  logic [1:0] sv_sym[$];
  logic       sv_err[$];
  int         sv_i[$];
  int         sv_q[$];
  int         st_cyc[$];
  logic       st_bit[$];

  demodulator dut (
    .clk_fast  (clk_fast),
    .rst       (rst),
    .in_valid  (in_valid),
    .wav_in    (wav_in),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_err   (sym_err),
    .corr_i    (corr_i),
    .corr_q    (corr_q),
    .bit_out   (bit_out),
    .bit_strobe(bit_strobe)
  );

  initial clk_fast = 1'b0;
  always #5 clk_fast = ~clk_fast;

  always @(posedge clk_fast) cyc <= cyc + 1;

  always @(negedge clk_fast) begin
    if (!rst) begin
      if (sym_valid) begin
        sv_cyc.push_back(cyc);
        sv_sym.push_back(sym_out);
        sv_err.push_back(sym_err);
        sv_i.push_back(int'(corr_i));
        sv_q.push_back(int'(corr_q));
      end
      if (bit_strobe) begin
        st_cyc.push_back(cyc);
        st_bit.push_back(bit_out);
      end
    end
  end

  task automatic clear_logs();
    sv_cyc.delete(); sv_sym.delete(); sv_err.delete(); sv_i.delete(); sv_q.delete();
    st_cyc.delete(); st_bit.delete();
  endtask

  task automatic send_sample(input int v);
    in_valid = 1'b1;
    wav_in   = 8'(v);
    @(posedge clk_fast);
    #1;
  endtask

  task automatic send_symbol(input int a, input int n);
    for (int k = 0; k < n; k++) send_sample(128 + sinv[(k + a) % 32]);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    wav_in   = 8'd128;
    repeat (n) begin
      @(posedge clk_fast);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({sym_out, sym_valid, sym_err, corr_i, corr_q, bit_out, bit_strobe} !== '0) begin
      errors++;
      $display("FAIL %s outputs got sym=%b v=%b e=%b i=%0d q=%0d bit=%b stb=%b want all 0",
               tag, sym_out, sym_valid, sym_err, corr_i, corr_q, bit_out, bit_strobe);
    end
  endtask

  task automatic test_reset();
    int s0;
    rst = 1'b1; in_valid = 1'b0; wav_in = 8'd128;
    repeat (3) @(posedge clk_fast);
    #1;
    check_all_zero("reset_initial");
    rst = 1'b0;
    send_symbol(16, 32);
    send_symbol(16, 10);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk_fast);
    #1;
    rst = 1'b0;
    clear_logs();
    s0 = cyc + 1;
    send_symbol(16, 32);
    idle(3);
    checks++;
    if (sv_cyc.size() !== 1) begin
      errors++; $display("FAIL reset_count got %0d want 1", sv_cyc.size());
    end else begin
      checks++;
      if (sv_cyc[0] !== s0 + 31) begin
        errors++; $display("FAIL reset_latency got %0d want %0d", sv_cyc[0], s0 + 31);
      end
      checks++;
      if (sv_sym[0] !== 2'b11) begin
        errors++; $display("FAIL reset_sym got %b want 11", sv_sym[0]);
      end
    end
  endtask

  task automatic test_single_symbols();
    int         a_list [4] = '{0, 8, 16, 24};
    logic [1:0] s_exp  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         i_exp  [4] = '{259126, 0, -259126, 0};
    int         q_exp  [4] = '{0, 259126, 0, -259126};
    for (int n = 0; n < 4; n++) begin
      clear_logs();
      send_symbol(a_list[n], 32);
      idle(3);
      checks++;
      if (sv_cyc.size() !== 1) begin
        errors++; $display("FAIL single_count a=%0d got %0d want 1", a_list[n], sv_cyc.size());
      end else begin
        checks++;
        if (sv_sym[0] !== s_exp[n] || sv_err[0] !== 1'b0) begin
          errors++;
          $display("FAIL single_sym a=%0d got sym=%b err=%b want sym=%b err=0",
                   a_list[n], sv_sym[0], sv_err[0], s_exp[n]);
        end
        checks++;
        if (sv_i[0] !== i_exp[n] || sv_q[0] !== q_exp[n]) begin
          errors++;
          $display("FAIL single_corr a=%0d got i=%0d q=%0d want i=%0d q=%0d",
                   a_list[n], sv_i[0], sv_q[0], i_exp[n], q_exp[n]);
        end
      end
    end
  endtask

  task automatic test_continuous();
    int         a_list [4] = '{24, 8, 16, 0};
    logic [1:0] s_exp  [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic       b_exp  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int s0;
    idle(40);
    clear_logs();
    s0 = cyc + 1;
    for (int n = 0; n < 4; n++) send_symbol(a_list[n], 32);
    idle(70);
    checks++;
    if (sv_cyc.size() !== 4) begin
      errors++; $display("FAIL cont_sym_count got %0d want 4", sv_cyc.size());
    end else begin
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (sv_sym[n] !== s_exp[n]) begin
          errors++; $display("FAIL cont_sym[%0d] got %b want %b", n, sv_sym[n], s_exp[n]);
        end
      end
    end
    checks++;
    if (st_cyc.size() !== 8) begin
      errors++; $display("FAIL cont_strobe_count got %0d want 8", st_cyc.size());
    end else begin
      checks++;
      if (st_cyc[0] !== s0 + 32) begin
        errors++; $display("FAIL cont_first_strobe got %0d want %0d", st_cyc[0], s0 + 32);
      end
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (st_bit[n] !== b_exp[n]) begin
          errors++; $display("FAIL cont_bit[%0d] got %b want %b", n, st_bit[n], b_exp[n]);
        end
        if (n > 0) begin
          checks++;
          if (st_cyc[n] - st_cyc[n-1] !== 16) begin
            errors++;
            $display("FAIL cont_spacing[%0d] got %0d want 16", n, st_cyc[n] - st_cyc[n-1]);
          end
        end
      end
    end
  endtask

  task automatic test_alignment();
    int s0;
    clear_logs();
    send_symbol(16, 17);
    idle(1);
    s0 = cyc + 1;
    send_symbol(16, 32);
    idle(3);
    checks++;
    if (sv_cyc.size() !== 1) begin
      errors++; $display("FAIL align_count got %0d want 1", sv_cyc.size());
    end else begin
      checks++;
      if (sv_cyc[0] !== s0 + 31 || sv_sym[0] !== 2'b11) begin
        errors++;
        $display("FAIL align_sym got cyc=%0d sym=%b want cyc=%0d sym=11", sv_cyc[0], sv_sym[0], s0 + 31);
      end
    end
  endtask

  task automatic test_weak();
    clear_logs();
    for (int k = 0; k < 32; k++) send_sample(128);
    idle(3);
    checks++;
    if (sv_cyc.size() !== 1) begin
      errors++; $display("FAIL weak_count got %0d want 1", sv_cyc.size());
    end else begin
      checks++;
      if (sv_i[0] !== 0 || sv_q[0] !== 0 || sv_sym[0] !== 2'b00 || sv_err[0] !== 1'b1) begin
        errors++;
        $display("FAIL weak got i=%0d q=%0d sym=%b err=%b want i=0 q=0 sym=00 err=1",
                 sv_i[0], sv_q[0], sv_sym[0], sv_err[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic b_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    idle(40);
    clear_logs();
    send_symbol(0, 32);
    send_symbol(8, 32);
    idle(40);
    checks++;
    if (sv_cyc.size() !== 2 || st_cyc.size() !== 4) begin
      errors++;
      $display("FAIL b2b_counts got sv=%0d st=%0d want sv=2 st=4", sv_cyc.size(), st_cyc.size());
    end else begin
      checks++;
      if (sv_cyc[1] - st_cyc[0] !== 31) begin
        errors++; $display("FAIL b2b_reload_cycle got %0d want 31", sv_cyc[1] - st_cyc[0]);
      end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (st_bit[n] !== b_exp[n]) begin
          errors++; $display("FAIL b2b_bit[%0d] got %b want %b", n, st_bit[n], b_exp[n]);
        end
        if (n > 0) begin
          checks++;
          if (st_cyc[n] - st_cyc[n-1] !== 16) begin
            errors++;
            $display("FAIL b2b_spacing[%0d] got %0d want 16", n, st_cyc[n] - st_cyc[n-1]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_symbols();
    test_continuous();
    test_alignment();
    test_weak();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
